// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-ported synchronous SRAM
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   if_req/if_addr            fetch read request (held until if_ready)
//   if_rdata/if_ready         fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  data-stage load/store request (held until mem_ready)
//   mem_rdata/mem_ready       load data and one-cycle completion pulse
//   sram_addr/sram_wdata/sram_rdata/sram_we/sram_oe  SRAM side; sram_addr[17] selects data region
// Parameter WAIT (1..15): SRAM access cycles per transaction.
// Optional macro MEM_ARBITER_IBUF_EN: one-entry fetch buffer, hits complete IDLE->DONE.
module mem_arbiter #(
  parameter int WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_we,
  output logic        sram_oe
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        owner_mem;   // 1 = data stage owns the current transaction
  logic        we_q;
  logic [3:0]  cnt;
  logic        last_cycle;
  logic        start;       // IDLE -> ACCESS this cycle
  logic        ibuf_hit;    // IDLE -> DONE straight from the fetch buffer
  logic        ibuf_lookup;
  logic [31:0] ibuf_rdata;

  // Address bits outside the 17-bit word window are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:19], if_addr[1:0], mem_addr[31:19], mem_addr[1:0]};

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    ibuf_hit   = 1'b0;
    last_cycle = (cnt == 4'(WAIT - 1));
    case (state)
      IDLE: begin
        if (ibuf_lookup) begin
          state_nxt = DONE;
          ibuf_hit  = 1'b1;
        end else if (mem_req || if_req) begin
          state_nxt = ACCESS;
          start     = 1'b1;
        end
      end
      ACCESS:  if (last_cycle) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner_mem  <= 1'b0;
      we_q       <= 1'b0;
      sram_addr  <= 18'd0;
      sram_wdata <= 32'd0;
      if_rdata   <= 32'd0;
      mem_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        // Data stage wins ties so a stalled pipeline drains first.
        owner_mem  <= mem_req;
        we_q       <= mem_req & mem_we;
        sram_addr  <= mem_req ? {1'b1, mem_addr[18:2]} : {1'b0, if_addr[18:2]};
        sram_wdata <= mem_wdata;
        cnt        <= 4'd0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
      end
      if (state == ACCESS && last_cycle) begin
        if (owner_mem) mem_rdata <= sram_rdata;
        else           if_rdata  <= sram_rdata;
      end
      if (ibuf_hit) begin
        owner_mem <= 1'b0;
        we_q      <= 1'b0;
        if_rdata  <= ibuf_rdata;
      end
    end
  end

`ifdef MEM_ARBITER_IBUF_EN
  logic        ibuf_valid;
  logic [29:0] ibuf_tag;
  logic [29:0] fetch_tag;   // full word address of the fetch in flight
  logic [31:0] ibuf_data;

  assign ibuf_lookup = if_req && !mem_req && ibuf_valid && (ibuf_tag == if_addr[31:2]);
  assign ibuf_rdata  = ibuf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ibuf_valid <= 1'b0;
      ibuf_tag   <= 30'd0;
      fetch_tag  <= 30'd0;
      ibuf_data  <= 32'd0;
    end else begin
      if (start) fetch_tag <= if_addr[31:2];
      // Any store may overwrite code, so drop the entry rather than compare.
      if (start && mem_req && mem_we) begin
        ibuf_valid <= 1'b0;
      end else if (state == ACCESS && last_cycle && !owner_mem) begin
        ibuf_valid <= 1'b1;
        ibuf_tag   <= fetch_tag;
        ibuf_data  <= sram_rdata;
      end
    end
  end
`else
  assign ibuf_lookup = 1'b0;
  assign ibuf_rdata  = 32'd0;
`endif

  assign sram_we   = (state == ACCESS) &  we_q;
  assign sram_oe   = (state == ACCESS) & ~we_q;
  assign if_ready  = (state == DONE)   & ~owner_mem;
  assign mem_ready = (state == DONE)   &  owner_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, sram_we, sram_oe;
  logic [17:0] sram_addr;

  logic        if_req_2;
  logic [31:0] if_addr_2;
  logic [31:0] if_rdata_2, mem_rdata_2, sram_wdata_2, sram_rdata_2;
  logic        if_ready_2, mem_ready_2, sram_we_2, sram_oe_2;
  logic [17:0] sram_addr_2;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we(sram_we), .sram_oe(sram_oe)
  );

  mem_arbiter #(.WAIT(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_2), .if_addr(if_addr_2), .if_rdata(if_rdata_2), .if_ready(if_ready_2),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'd0), .mem_wdata(32'd0),
    .mem_rdata(mem_rdata_2), .mem_ready(mem_ready_2),
    .sram_addr(sram_addr_2), .sram_wdata(sram_wdata_2), .sram_rdata(sram_rdata_2),
    .sram_we(sram_we_2), .sram_oe(sram_oe_2)
  );

  // SRAM model: unwritten words read back as 0xC0DE0000 | index.
  logic [31:0] sram_mem [0:1023];
  logic        sram_wr  [0:1023];
  logic [9:0]  sidx;
  assign sidx = {sram_addr[17], sram_addr[8:0]};
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) sram_wr[i] <= 1'b0;
    end else if (sram_we) begin
      sram_mem[sidx] <= sram_wdata;
      sram_wr[sidx]  <= 1'b1;
    end
  end
  assign sram_rdata   = sram_wr[sidx] ? sram_mem[sidx] : (32'hC0DE0000 | {22'd0, sidx});
  assign sram_rdata_2 = 32'h5A5A0000 | {14'd0, sram_addr_2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    if_req_2 = 1'b0; if_addr_2 = 32'd0;
    tick; tick;

    chk("rst_we", sram_we, 0);
    chk("rst_oe", sram_oe, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    rst = 1'b1;

    // Single fetch of 0x8: 4 read cycles then if_ready in cycle 6.
    if_req = 1'b1; if_addr = 32'h8;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("f1_oe", sram_oe, 1);
      chk("f1_addr", sram_addr, 18'h00002);
      chk("f1_rdy_early", if_ready, 0);
    end
    tick;
    chk("f1_ready", if_ready, 1);
    chk("f1_rdata", if_rdata, 32'hC0DE0002);
    chk("f1_oe_done", sram_oe, 0);
    chk("f1_mem_ready", mem_ready, 0);
    if_req = 1'b0;
    tick;
    chk("f1_ready_pulse", if_ready, 0);
    chk("f1_rdata_hold", if_rdata, 32'hC0DE0002);

    // Simultaneous store + fetch: store wins, fetch follows from the next IDLE.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h0000060A;
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("st_we", sram_we, 1);
      chk("st_oe", sram_oe, 0);
      chk("st_addr", sram_addr, 18'h20100);
      chk("st_wdata", sram_wdata, 32'h0000060A);
      chk("st_if_ready", if_ready, 0);
    end
    tick;
    chk("st_mem_ready", mem_ready, 1);
    chk("st_if_ready_done", if_ready, 0);
    chk("st_we_done", sram_we, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;
    chk("arb_idle_oe", sram_oe, 0);
    chk("arb_idle_ready", if_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("f2_oe", sram_oe, 1);
      chk("f2_addr", sram_addr, 18'h00004);
    end
    tick;
    chk("f2_ready", if_ready, 1);
    chk("f2_rdata", if_rdata, 32'hC0DE0004);
    if_req = 1'b0;
    tick;

    // Store then load back 0x404.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h404; mem_wdata = 32'hFFFFF9F6;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("st2_addr", sram_addr, 18'h20101);
      chk("st2_we", sram_we, 1);
    end
    tick;
    chk("st2_ready", mem_ready, 1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;
    mem_req = 1'b1; mem_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("ld_oe", sram_oe, 1);
      chk("ld_we", sram_we, 0);
    end
    tick;
    chk("ld_ready", mem_ready, 1);
    chk("ld_rdata", mem_rdata, 32'hFFFFF9F6);
    chk("ld_if_ready", if_ready, 0);
    chk("ld_if_rdata_hold", if_rdata, 32'hC0DE0004);
    mem_req = 1'b0;
    tick;

    // Reset in the second ACCESS cycle of a store, request held throughout.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h408; mem_wdata = 32'h12345678;
    tick;
    chk("rs_we1", sram_we, 1);
    tick;
    chk("rs_we2", sram_we, 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_we_async", sram_we, 0);
    chk("rs_addr_async", sram_addr, 0);
    chk("rs_mem_ready", mem_ready, 0);
    chk("rs_mem_rdata", mem_rdata, 0);
    chk("rs_if_rdata", if_rdata, 0);
    tick;
    chk("rs_hold_ready", mem_ready, 0);
    chk("rs_hold_we", sram_we, 0);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("rs_re_we", sram_we, 1);
      chk("rs_re_addr", sram_addr, 18'h20102);
      chk("rs_re_wdata", sram_wdata, 32'h12345678);
    end
    tick;
    chk("rs_re_ready", mem_ready, 1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;

    // Repeated fetch of 0x10.
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("rf1_oe", sram_oe, 1);
    end
    tick;
    chk("rf1_ready", if_ready, 1);
    chk("rf1_rdata", if_rdata, 32'hC0DE0004);
    if_req = 1'b0;
    tick;
    if_req = 1'b1;
    tick;
`ifdef MEM_ARBITER_IBUF_EN
    chk("rf2_hit_ready", if_ready, 1);
    chk("rf2_hit_oe", sram_oe, 0);
    chk("rf2_hit_rdata", if_rdata, 32'hC0DE0004);
`else
    chk("rf2_oe", sram_oe, 1);
    chk("rf2_ready_early", if_ready, 0);
    tick; tick; tick; tick;
    chk("rf2_ready", if_ready, 1);
    chk("rf2_rdata", if_rdata, 32'hC0DE0004);
`endif
    if_req = 1'b0;
    tick;

    // A store in between forces a full-latency refetch.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40C; mem_wdata = 32'hA5A5A5A5;
    tick; tick; tick; tick; tick;
    chk("inv_st_ready", mem_ready, 1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("rf3_oe", sram_oe, 1);
      chk("rf3_ready_early", if_ready, 0);
    end
    tick;
    chk("rf3_ready", if_ready, 1);
    chk("rf3_rdata", if_rdata, 32'hC0DE0004);
    if_req = 1'b0;
    tick;

    // WAIT=1, fetch held high: ready every third cycle, new address each time.
    if_req_2 = 1'b1; if_addr_2 = 32'h20;
    for (int k = 1; k <= 9; k++) begin
      tick;
      chk("w1_ready", if_ready_2, (k % 3 == 2));
      chk("w1_oe", sram_oe_2, (k % 3 == 1));
      if (k % 3 == 2) begin
        chk("w1_rdata", if_rdata_2, 32'h5A5A0008 + 32'(k / 3));
        if_addr_2 = if_addr_2 + 32'd4;
      end
    end
    if_req_2 = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
